// File: rtl/pc_fetch_unit.sv
// IF-stage program counter and instruction-fetch controller.
// Runs a single-outstanding req/ack fetch, parks an acked word in a skid register during stalls,
// and drains a stale request after a redirect.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCAddResult,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Stall,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] PCResult,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  output logic [31:0] InstrOut,
  output logic [31:0] InstrPC,
  output logic        InstrValid
);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] drain_addr;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic [31:0] redirect_pc;
  logic        target_lsbs_unused;

  logic        fetch_done;
  logic        deliver_now;
  logic        park;
  logic        release_skid;
  logic        start_drain;

  // Targets are always word aligned; the low target bits are deliberately dropped.
  assign redirect_pc        = {BranchTarget[31:2], 2'b00};
  assign target_lsbs_unused = ^BranchTarget[1:0];

  always_comb begin
    fetch_done   = (state == REQ) && IMemAck && !BranchTaken;
    deliver_now  = fetch_done && !Stall;
    park         = fetch_done && Stall;
    release_skid = (state == HOLD) && !BranchTaken && !Stall;
    start_drain  = (state == REQ) && BranchTaken && !IMemAck;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= REQ;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      REQ: begin
        if (BranchTaken) begin
          state_next = IMemAck ? REQ : DRAIN;
        end else if (IMemAck && Stall) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (BranchTaken || !Stall) begin
          state_next = REQ;
        end
      end
      DRAIN: begin
        if (IMemAck) begin
          state_next = REQ;
        end
      end
      default: state_next = REQ;
    endcase
  end

  // The request line is masked by Reset so memory sees nothing while the unit is held in reset.
  always_comb begin
    IMemReq  = 1'b0;
    IMemAddr = PCResult;
    unique case (state)
      REQ: begin
        IMemReq  = !Reset;
        IMemAddr = PCResult;
      end
      HOLD: begin
        IMemReq  = 1'b0;
        IMemAddr = PCResult;
      end
      DRAIN: begin
        IMemReq  = !Reset;
        IMemAddr = drain_addr;
      end
      default: begin
        IMemReq  = 1'b0;
        IMemAddr = PCResult;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      PCResult <= RESET_PC;
    end else if (BranchTaken) begin
      PCResult <= redirect_pc;
    end else if (fetch_done) begin
      PCResult <= PCAddResult;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      drain_addr <= 32'h0;
    end else if (start_drain) begin
      drain_addr <= PCResult;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
    end else if (park) begin
      skid_instr <= IMemData;
      skid_pc    <= PCResult;
    end
  end

  // A redirect flushes the IF/ID outputs even when the hazard unit is stalling.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      InstrOut   <= 32'h0;
      InstrPC    <= 32'h0;
      InstrValid <= 1'b0;
    end else if (BranchTaken) begin
      InstrValid <= 1'b0;
    end else if (deliver_now) begin
      InstrOut   <= IMemData;
      InstrPC    <= PCResult;
      InstrValid <= 1'b1;
    end else if (release_skid) begin
      InstrOut   <= skid_instr;
      InstrPC    <= skid_pc;
      InstrValid <= 1'b1;
    end else if (state == DRAIN) begin
      InstrValid <= 1'b0;
    end else if ((state == REQ) && !IMemAck && !Stall) begin
      InstrValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized run
// checked against a queue-based reference model of the fetch behaviour.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clk;
  logic        Reset;
  logic [31:0] PCAddResult;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Stall;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic [31:0] PCResult;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] InstrOut;
  logic [31:0] InstrPC;
  logic        InstrValid;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: current PC, IF/ID outputs, parked words, and an optional stale request.
  logic [31:0] m_pc, m_out, m_opc, m_stale_addr;
  logic        m_valid, m_stale, m_rst;
  logic [63:0] m_skid[$];

  pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .Clk(Clk), .Reset(Reset), .PCAddResult(PCAddResult), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Stall(Stall), .IMemAck(IMemAck), .IMemData(IMemData),
    .PCResult(PCResult), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .InstrOut(InstrOut),
    .InstrPC(InstrPC), .InstrValid(InstrValid)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic model_update(input logic rst, input logic br, input logic [31:0] tgt,
                              input logic stl, input logic ack, input logic [31:0] data);
    logic [63:0] w;
    m_rst = rst;
    if (rst) begin
      m_pc = RESET_PC; m_out = 0; m_opc = 0; m_valid = 0; m_stale = 0; m_stale_addr = 0;
      m_skid.delete();
    end else if (m_skid.size() != 0) begin
      if (br) begin
        m_skid.delete(); m_pc = tgt & ~32'd3; m_valid = 0;
      end else if (!stl) begin
        w = m_skid.pop_front(); m_out = w[63:32]; m_opc = w[31:0]; m_valid = 1;
      end
    end else if (m_stale) begin
      m_valid = 0;
      if (br) m_pc = tgt & ~32'd3;
      if (ack) m_stale = 0;
    end else begin
      if (br) begin
        if (!ack) begin m_stale = 1; m_stale_addr = m_pc; end
        m_pc = tgt & ~32'd3; m_valid = 0;
      end else if (ack) begin
        if (stl) m_skid.push_back({data, m_pc});
        else begin m_out = data; m_opc = m_pc; m_valid = 1; end
        m_pc = m_pc + 32'd4;
      end else if (!stl) begin
        m_valid = 0;
      end
    end
  endtask

  // One clock of stimulus; memory returns addr+0x100 and only acks a live request.
  task automatic step(input logic rst, input logic br, input logic [31:0] tgt,
                      input logic stl, input logic ack);
    Reset = rst; BranchTaken = br; BranchTarget = tgt; Stall = stl;
    #1;
    IMemAck     = ack && !rst && IMemReq;
    IMemData    = IMemAck ? IMemAddr + 32'h100 : 32'hDEAD_BEEF;
    PCAddResult = PCResult + 32'd4;
    model_update(rst, br, tgt, stl, IMemAck, IMemData);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (PCResult !== RESET_PC) begin miscompares++; $display("FAIL reset_pc: got %h want %h", PCResult, RESET_PC); end
    vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", InstrValid); end
    vectors++; if (InstrOut !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 0", InstrOut); end
    vectors++; if (InstrPC !== 32'h0) begin miscompares++; $display("FAIL reset_instrpc: got %h want 0", InstrPC); end
    vectors++; if (IMemReq !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", IMemReq); end
  endtask

  task automatic test_sequential();
    do_reset();
    vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL seq_first_valid: got %b want 0", InstrValid); end
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 1);
      vectors++; if (InstrValid !== 1'b1) begin miscompares++; $display("FAIL seq_valid[%0d]: got %b want 1", i, InstrValid); end
      vectors++; if (InstrPC !== 32'(4 * i)) begin miscompares++; $display("FAIL seq_instrpc[%0d]: got %h want %h", i, InstrPC, 32'(4 * i)); end
      vectors++; if (InstrOut !== 32'(4 * i + 256)) begin miscompares++; $display("FAIL seq_instr[%0d]: got %h want %h", i, InstrOut, 32'(4 * i + 256)); end
      vectors++; if (PCResult !== 32'(4 * i + 4)) begin miscompares++; $display("FAIL seq_pc[%0d]: got %h want %h", i, PCResult, 32'(4 * i + 4)); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, (i == 0));
      vectors++; if (InstrPC !== 32'h4) begin miscompares++; $display("FAIL stall_hold_pc[%0d]: got %h want 4", i, InstrPC); end
      vectors++; if (InstrOut !== 32'h104) begin miscompares++; $display("FAIL stall_hold_instr[%0d]: got %h want 104", i, InstrOut); end
      vectors++; if (InstrValid !== 1'b1) begin miscompares++; $display("FAIL stall_hold_valid[%0d]: got %b want 1", i, InstrValid); end
      vectors++; if (PCResult !== 32'hC) begin miscompares++; $display("FAIL stall_pc[%0d]: got %h want c", i, PCResult); end
      vectors++; if (IMemReq !== 1'b0) begin miscompares++; $display("FAIL stall_req[%0d]: got %b want 0", i, IMemReq); end
    end
    step(0, 0, 0, 0, 0);
    vectors++; if (InstrPC !== 32'h8) begin miscompares++; $display("FAIL release_instrpc: got %h want 8", InstrPC); end
    vectors++; if (InstrOut !== 32'h108) begin miscompares++; $display("FAIL release_instr: got %h want 108", InstrOut); end
    vectors++; if (InstrValid !== 1'b1) begin miscompares++; $display("FAIL release_valid: got %b want 1", InstrValid); end
    vectors++; if (IMemAddr !== 32'hC) begin miscompares++; $display("FAIL release_addr: got %h want c", IMemAddr); end
    step(0, 0, 0, 0, 1);
    vectors++; if (InstrPC !== 32'hC) begin miscompares++; $display("FAIL after_release_instrpc: got %h want c", InstrPC); end
    vectors++; if (PCResult !== 32'h10) begin miscompares++; $display("FAIL after_release_pc: got %h want 10", PCResult); end
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    vectors++; if (IMemAddr !== 32'h10) begin miscompares++; $display("FAIL drain_req_addr: got %h want 10", IMemAddr); end
    vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL drain_wait_valid: got %b want 0", InstrValid); end
    step(0, 1, 32'h40, 0, 0);
    vectors++; if (PCResult !== 32'h40) begin miscompares++; $display("FAIL drain_pc: got %h want 40", PCResult); end
    vectors++; if (IMemAddr !== 32'h10) begin miscompares++; $display("FAIL drain_addr_hold: got %h want 10", IMemAddr); end
    vectors++; if (IMemReq !== 1'b1) begin miscompares++; $display("FAIL drain_req: got %b want 1", IMemReq); end
    step(0, 1, 32'h60, 0, 0);
    vectors++; if (PCResult !== 32'h60) begin miscompares++; $display("FAIL drain_newest_pc: got %h want 60", PCResult); end
    vectors++; if (IMemAddr !== 32'h10) begin miscompares++; $display("FAIL drain_addr_hold2: got %h want 10", IMemAddr); end
    step(0, 0, 0, 0, 1);
    vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL drain_discard_valid: got %b want 0", InstrValid); end
    vectors++; if (IMemAddr !== 32'h60) begin miscompares++; $display("FAIL drain_next_addr: got %h want 60", IMemAddr); end
    step(0, 0, 0, 0, 1);
    vectors++; if (InstrPC !== 32'h60) begin miscompares++; $display("FAIL drain_target_instrpc: got %h want 60", InstrPC); end
    vectors++; if (InstrOut !== 32'h160) begin miscompares++; $display("FAIL drain_target_instr: got %h want 160", InstrOut); end
  endtask

  task automatic test_branch_ack();
    do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 1, 32'h203, 0, 1);
    vectors++; if (PCResult !== 32'h200) begin miscompares++; $display("FAIL br_ack_pc: got %h want 200", PCResult); end
    vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL br_ack_valid: got %b want 0", InstrValid); end
    step(0, 0, 0, 0, 1);
    vectors++; if (InstrPC !== 32'h200) begin miscompares++; $display("FAIL br_target_instrpc: got %h want 200", InstrPC); end
    vectors++; if (InstrOut !== 32'h300) begin miscompares++; $display("FAIL br_target_instr: got %h want 300", InstrOut); end
    step(0, 0, 0, 1, 1);
    step(0, 1, 32'h80, 1, 0);
    vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL br_over_stall_valid: got %b want 0", InstrValid); end
    vectors++; if (IMemAddr !== 32'h80) begin miscompares++; $display("FAIL br_over_stall_addr: got %h want 80", IMemAddr); end
    step(0, 0, 0, 0, 1);
    vectors++; if (InstrPC !== 32'h80) begin miscompares++; $display("FAIL br_skid_discard: got %h want 80", InstrPC); end
  endtask

  task automatic test_wraparound();
    do_reset();
    step(0, 1, 32'hFFFF_FFFC, 0, 1);
    vectors++; if (PCResult !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_setup_pc: got %h want fffffffc", PCResult); end
    step(0, 0, 0, 0, 1);
    vectors++; if (PCResult !== 32'h0) begin miscompares++; $display("FAIL wrap_pc: got %h want 0", PCResult); end
    vectors++; if (InstrOut !== 32'hFC) begin miscompares++; $display("FAIL wrap_instr: got %h want fc", InstrOut); end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    step(0, 1, 32'h80, 0, 0);
    vectors++; if (IMemAddr !== 32'h0) begin miscompares++; $display("FAIL rdrain_addr: got %h want 0", IMemAddr); end
    step(1, 0, 0, 0, 0);
    vectors++; if (PCResult !== RESET_PC) begin miscompares++; $display("FAIL rdrain_pc: got %h want %h", PCResult, RESET_PC); end
    vectors++; if (IMemReq !== 1'b0) begin miscompares++; $display("FAIL rdrain_req: got %b want 0", IMemReq); end
    vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL rdrain_valid: got %b want 0", InstrValid); end
    step(0, 0, 0, 0, 1);
    vectors++; if (InstrValid !== 1'b1) begin miscompares++; $display("FAIL rdrain_nodrain_valid: got %b want 1", InstrValid); end
    vectors++; if (InstrPC !== RESET_PC) begin miscompares++; $display("FAIL rdrain_nodrain_pc: got %h want %h", InstrPC, RESET_PC); end
  endtask

  task automatic test_random();
    logic        rst, br, stl, pend, want;
    logic [31:0] tgt, exp_addr;
    int          wcnt;
    pend = 0; wcnt = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      br  = ($urandom_range(0, 7) == 0);
      stl = ($urandom_range(0, 3) == 0);
      tgt = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
      want = 1'b0;
      if (IMemReq) begin
        if (!pend) begin pend = 1; wcnt = $urandom_range(0, 2); end
        if (wcnt == 0) want = 1'b1;
        else wcnt--;
      end
      step(rst, br, tgt, stl, want);
      if (IMemAck || rst) pend = 0;
      exp_addr = m_stale ? m_stale_addr : m_pc;
      vectors++; if (PCResult !== m_pc) begin miscompares++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, PCResult, m_pc); end
      vectors++; if (IMemReq !== (!m_rst && m_skid.size() == 0)) begin miscompares++; $display("FAIL rnd_req[%0d]: got %b want %b", n, IMemReq, (!m_rst && m_skid.size() == 0)); end
      if (!m_rst && m_skid.size() == 0) begin
        vectors++; if (IMemAddr !== exp_addr) begin miscompares++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, IMemAddr, exp_addr); end
      end
      vectors++; if (InstrValid !== m_valid) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, InstrValid, m_valid); end
      vectors++; if (InstrOut !== m_out) begin miscompares++; $display("FAIL rnd_instr[%0d]: got %h want %h", n, InstrOut, m_out); end
      vectors++; if (InstrPC !== m_opc) begin miscompares++; $display("FAIL rnd_instrpc[%0d]: got %h want %h", n, InstrPC, m_opc); end
    end
  endtask

  initial begin
    Reset = 1; BranchTaken = 0; BranchTarget = 0; Stall = 0;
    IMemAck = 0; IMemData = 0; PCAddResult = 0;
    @(negedge Clk);
    test_reset();
    test_sequential();
    test_stall();
    test_drain();
    test_branch_ack();
    test_wraparound();
    test_reset_in_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
